// File: rtl/whack_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// whack_pkg : shared state encodings and widths for the whack-a-mole game.
// Rev 1.0
// ----------------------------------------------------------------------------
package whack_pkg;

  localparam int c_FSM_W   = 4;
  localparam int c_N_MOLES = 4;

  localparam logic [c_FSM_W-1:0] ST_START    = 4'd0;
  localparam logic [c_FSM_W-1:0] ST_GAME     = 4'd1;
  localparam logic [c_FSM_W-1:0] ST_MOLE1    = 4'd2;
  localparam logic [c_FSM_W-1:0] ST_MOLE2    = 4'd3;
  localparam logic [c_FSM_W-1:0] ST_MOLE3    = 4'd4;
  localparam logic [c_FSM_W-1:0] ST_MOLE4    = 4'd5;
  localparam logic [c_FSM_W-1:0] ST_GAMEOVER = 4'd6;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_GAP  = 2'd1,
    DP_MOLE = 2'd2,
    DP_ACK  = 2'd3
  } dp_state_t;

  function automatic logic is_mole(input logic [c_FSM_W-1:0] s);
    return (s >= ST_MOLE1) && (s <= ST_MOLE4);
  endfunction

  // One-hot mole select for a game-FSM state; zero outside the mole states.
  function automatic logic [c_N_MOLES-1:0] mole_onehot(input logic [c_FSM_W-1:0] s);
    logic [1:0] idx;
    idx = 2'(s - ST_MOLE1);
    return is_mole(s) ? (c_N_MOLES'(1) << idx) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/whack_key_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_sync_edge : 2-FF synchroniser plus registered rising-edge pulse per key.
// Rev 1.0
// ----------------------------------------------------------------------------
module key_sync_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] i_keys,
  output logic [N-1:0] o_hit
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;
  logic [N-1:0] r_prev;
  logic [N-1:0] r_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_hit  <= '0;
    end else begin
      r_meta <= i_keys;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_hit  <= r_sync & ~r_prev;
    end
  end

  assign o_hit = r_hit;

endmodule
`default_nettype wire

// File: rtl/whack_datapath.sv
`default_nettype none
// ----------------------------------------------------------------------------
// whack_datapath : mole spawn/retire pulses, round timer, score/miss counters.
// Option macro: WHACK_WRONG_KEY_PENALTY_EN (wrong key in a mole decrements score)
// Rev 1.0
// ----------------------------------------------------------------------------
module whack_datapath
  import whack_pkg::*;
#(
  parameter int unsigned GAME_CYCLES = 1_500_000_000,
  parameter int unsigned MOLE_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000,
  parameter int          SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         fsm_state,
  input  logic [3:0]         keys,
  output logic               control_signal,
  output logic               timer_signal,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [3:0]         mole_leds
);

  localparam int c_GAME_W = $clog2(GAME_CYCLES + 1);
  localparam int c_MOLE_W = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
  localparam int c_GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAME_W-1:0] c_GAME_LAST = c_GAME_W'(GAME_CYCLES - 1);
  localparam logic [c_MOLE_W-1:0] c_MOLE_LAST = c_MOLE_W'(MOLE_CYCLES - 1);
  localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0]  c_SAT       = '1;

  dp_state_t             r_state, w_next;
  logic [c_GAME_W-1:0]   r_game_cnt;
  logic [c_MOLE_W-1:0]   r_mole_cnt;
  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic [3:0]            r_cap;
  logic                  r_timer, r_ctl;
  logic [SCORE_W-1:0]    r_score, r_misses;
  logic [3:0]            r_leds;

  logic [3:0] w_hit, w_onehot;
  logic       w_start, w_over, w_active, w_expire, w_abort, w_match;
  logic       w_event, w_pulse, w_score_inc, w_score_dec, w_miss_inc, w_clr_gap, w_clr_mole;

  key_sync_edge #(.N(4)) u_keys (
    .clk     (clk),
    .reset_n (reset_n),
    .i_keys  (keys),
    .o_hit   (w_hit)
  );

  // Encodings 7..15 behave exactly like Start.
  assign w_start  = (fsm_state == ST_START) || (fsm_state > ST_GAMEOVER);
  assign w_over   = (fsm_state == ST_GAMEOVER);
  assign w_active = !w_start && !w_over;
  assign w_expire = w_active && !r_timer && (r_game_cnt == c_GAME_LAST);
  assign w_abort  = w_start || w_over || r_timer || w_expire;
  assign w_onehot = mole_onehot(fsm_state);
  assign w_match  = |(w_hit & w_onehot);
`ifdef WHACK_WRONG_KEY_PENALTY_EN
  logic w_wrong;
  assign w_wrong  = |(w_hit & ~w_onehot);
`endif

  always_comb begin
    w_next      = r_state;
    w_event     = 1'b0;
    w_score_inc = 1'b0;
    w_score_dec = 1'b0;
    w_miss_inc  = 1'b0;
    w_clr_gap   = 1'b0;
    w_clr_mole  = 1'b0;
    case (r_state)
      DP_IDLE: begin
        if (fsm_state == ST_GAME) begin
          w_next    = DP_GAP;
          w_clr_gap = 1'b1;
        end else if (is_mole(fsm_state)) begin
          w_next     = DP_MOLE;
          w_clr_mole = 1'b1;
        end
      end
      DP_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_event = 1'b1;
          w_next  = DP_ACK;
        end
      end
      DP_MOLE: begin
        if (w_match) begin
          w_score_inc = 1'b1;
          w_event     = 1'b1;
          w_next      = DP_ACK;
        end else begin
`ifdef WHACK_WRONG_KEY_PENALTY_EN
          w_score_dec = w_wrong;
`endif
          if (r_mole_cnt == c_MOLE_LAST) begin
            w_miss_inc = 1'b1;
            w_event    = 1'b1;
            w_next     = DP_ACK;
          end
        end
      end
      DP_ACK: begin
        // Hold until the game FSM has acted on the pulse, so one move = one pulse.
        if (fsm_state != r_cap) begin
          if (fsm_state == ST_GAME) begin
            w_next    = DP_GAP;
            w_clr_gap = 1'b1;
          end else if (is_mole(fsm_state)) begin
            w_next     = DP_MOLE;
            w_clr_mole = 1'b1;
          end else begin
            w_next = DP_IDLE;
          end
        end
      end
      default: w_next = DP_IDLE;
    endcase
    if (w_abort) w_next = DP_IDLE;
  end

  assign w_pulse = w_event && !w_abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= DP_IDLE;
      r_game_cnt <= '0;
      r_mole_cnt <= '0;
      r_gap_cnt  <= '0;
      r_cap      <= '0;
      r_timer    <= 1'b0;
      r_ctl      <= 1'b0;
      r_score    <= '0;
      r_misses   <= '0;
      r_leds     <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= w_pulse;
      r_leds  <= (w_next == DP_MOLE) ? w_onehot : 4'd0;
      if (w_pulse) r_cap <= fsm_state;

      if (w_clr_gap)             r_gap_cnt <= '0;
      else if (r_state == DP_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;

      if (w_clr_mole)             r_mole_cnt <= '0;
      else if (r_state == DP_MOLE) r_mole_cnt <= r_mole_cnt + 1'b1;

      if (w_start) begin
        r_game_cnt <= '0;
        r_timer    <= 1'b0;
      end else if (w_active && !r_timer) begin
        if (w_expire) r_timer    <= 1'b1;
        else          r_game_cnt <= r_game_cnt + 1'b1;
      end

      // Start clears the tallies; GameOver keeps them on display.
      if (w_start) begin
        r_score  <= '0;
        r_misses <= '0;
      end else begin
        if (w_score_inc && (r_score != c_SAT))       r_score <= r_score + 1'b1;
        else if (w_score_dec && (r_score != '0))     r_score <= r_score - 1'b1;
        if (w_miss_inc && (r_misses != c_SAT))       r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign control_signal = r_ctl;
  assign timer_signal   = r_timer;
  assign score          = r_score;
  assign misses         = r_misses;
  assign mole_leds      = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_whack_datapath.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_whack_datapath : directed self-checking bench for whack_datapath.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_whack_datapath;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] fsm_state;
  logic [3:0] keys;

  logic       ctl, tmr;
  logic [7:0] score, misses;
  logic [3:0] leds;
  logic       s_ctl, s_tmr;
  logic [7:0] s_score, s_misses;
  logic [3:0] s_leds;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  whack_datapath #(.GAME_CYCLES(200), .MOLE_CYCLES(20), .GAP_CYCLES(5), .SCORE_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .fsm_state(fsm_state), .keys(keys),
    .control_signal(ctl), .timer_signal(tmr), .score(score), .misses(misses), .mole_leds(leds)
  );

  // Long round so the score can be driven to saturation without the timer expiring.
  whack_datapath #(.GAME_CYCLES(100000), .MOLE_CYCLES(20), .GAP_CYCLES(5), .SCORE_W(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .fsm_state(fsm_state), .keys(keys),
    .control_signal(s_ctl), .timer_signal(s_tmr), .score(s_score), .misses(s_misses), .mole_leds(s_leds)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter mole m from a differing state, press its key, wait for the retire pulse.
  task automatic do_hit(input int m);
    bit seen;
    fsm_state = 4'(m + 2);
    keys = '0;
    tick(1);
    keys[m] = 1'b1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(1);
      if (s_ctl) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL hit_ack: no control pulse within 8 cycles for mole %0d", m);
    end
    keys = '0;
    tick(3);
  endtask

  task automatic test_reset();
    int pulses;
    reset_n = 1'b0; fsm_state = 4'd0; keys = '0;
    tick(2);
    n_checks++;
    if ({ctl, tmr, score, misses, leds} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected 0", {ctl, tmr, score, misses, leds});
    end
    reset_n = 1'b1;
    tick(2);
    do_hit(0); do_hit(1); do_hit(0);
    n_checks++;
    if (score !== 8'd3) begin n_errors++; $display("FAIL pre_reset_score: got %0d expected 3", score); end
    fsm_state = 4'd3;
    tick(2);
    n_checks++;
    if (leds !== 4'b0010) begin n_errors++; $display("FAIL pre_reset_leds: got %b expected 0010", leds); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ctl, tmr, score, misses, leds} !== 22'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected 0", {ctl, tmr, score, misses, leds});
    end
    fsm_state = 4'd0;
    tick(2);
    reset_n = 1'b1;
    pulses = 0;
    repeat (8) begin tick(1); if (ctl) pulses++; end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL post_reset_pulse: got %0d expected 0", pulses); end
    n_checks++;
    if (score !== 8'd0) begin n_errors++; $display("FAIL post_reset_score: got %0d expected 0", score); end
  endtask

  task automatic test_gap();
    int pulses;
    fsm_state = 4'd0; tick(2);
    fsm_state = 4'd1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      n_checks++;
      if (ctl !== (i == 6)) begin
        n_errors++;
        $display("FAIL gap_pulse cycle %0d: got %b expected %b", i, ctl, (i == 6));
      end
    end
    pulses = 0;
    repeat (20) begin tick(1); if (ctl) pulses++; end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL gap_second_pulse: got %0d expected 0", pulses); end
  endtask

  task automatic test_hit();
    fsm_state = 4'd0; tick(2);
    fsm_state = 4'd3;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      n_checks++;
      if (ctl !== (i == 8)) begin
        n_errors++; $display("FAIL hit_ctl cycle %0d: got %b expected %b", i, ctl, (i == 8));
      end
      n_checks++;
      if (score !== ((i >= 8) ? 8'd1 : 8'd0)) begin
        n_errors++; $display("FAIL hit_score cycle %0d: got %0d expected %0d", i, score, (i >= 8));
      end
      n_checks++;
      if (leds !== ((i < 8) ? 4'b0010 : 4'b0000)) begin
        n_errors++; $display("FAIL hit_leds cycle %0d: got %b expected %b", i, leds, ((i < 8) ? 4'b0010 : 4'b0000));
      end
      if (i == 4) keys = 4'b0010;
    end
    keys = '0;
  endtask

  task automatic test_timeout();
    fsm_state = 4'd0; tick(2);
    fsm_state = 4'd4;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      n_checks++;
      if (ctl !== (i == 21)) begin
        n_errors++; $display("FAIL miss_ctl cycle %0d: got %b expected %b", i, ctl, (i == 21));
      end
      if (i == 21) begin
        n_checks++;
        if (misses !== 8'd1) begin n_errors++; $display("FAIL miss_count: got %0d expected 1", misses); end
      end
    end
    fsm_state = 4'd5;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      n_checks++;
      if (ctl !== (i == 21)) begin
        n_errors++; $display("FAIL tie_ctl cycle %0d: got %b expected %b", i, ctl, (i == 21));
      end
      if (i == 21) begin
        n_checks++;
        if (score !== 8'd1) begin n_errors++; $display("FAIL tie_score: got %0d expected 1", score); end
        n_checks++;
        if (misses !== 8'd1) begin n_errors++; $display("FAIL tie_misses: got %0d expected 1", misses); end
      end
      if (i == 17) keys = 4'b1000;
    end
    keys = '0;
  endtask

  task automatic test_timer();
    int pulses;
    fsm_state = 4'd0; tick(2);
    fsm_state = 4'd1;
    pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (i > 190 && ctl) pulses++;
      if (i == 199) begin
        n_checks++;
        if (tmr !== 1'b0) begin n_errors++; $display("FAIL timer_early: got %b expected 0", tmr); end
      end
      if (i == 200) begin
        n_checks++;
        if (tmr !== 1'b1) begin n_errors++; $display("FAIL timer_expire: got %b expected 1", tmr); end
        n_checks++;
        if (score !== 8'd1) begin n_errors++; $display("FAIL expire_hit_score: got %0d expected 1", score); end
      end
      if (i == 190) fsm_state = 4'd2;
      if (i == 196) keys = 4'b0001;
    end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL expire_ctl: got %0d pulses expected 0", pulses); end
    keys = '0; tick(3);
    fsm_state = 4'd3; tick(1);
    keys = 4'b0010;
    pulses = 0;
    repeat (8) begin tick(1); if (ctl) pulses++; end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL timer_hold_ctl: got %0d pulses expected 0", pulses); end
    n_checks++;
    if ({tmr, score, leds} !== {1'b1, 8'd1, 4'd0}) begin
      n_errors++; $display("FAIL timer_hold: got tmr=%b score=%0d leds=%b expected 1/1/0000", tmr, score, leds);
    end
    keys = '0;
    fsm_state = 4'd0; tick(1);
    n_checks++;
    if ({tmr, score} !== 9'd0) begin
      n_errors++; $display("FAIL start_clear: got tmr=%b score=%0d expected 0/0", tmr, score);
    end
  endtask

  task automatic test_penalty();
    int pulses;
    logic [7:0] exp_score;
`ifdef WHACK_WRONG_KEY_PENALTY_EN
    exp_score = 8'd1;
`else
    exp_score = 8'd2;
`endif
    fsm_state = 4'd0; tick(2);
    do_hit(0); do_hit(1);
    n_checks++;
    if (score !== 8'd2) begin n_errors++; $display("FAIL penalty_setup: got %0d expected 2", score); end
    fsm_state = 4'd2; tick(1);
    keys = 4'b1000;
    pulses = 0;
    repeat (8) begin tick(1); if (ctl) pulses++; end
    n_checks++;
    if (score !== exp_score) begin n_errors++; $display("FAIL wrong_key_score: got %0d expected %0d", score, exp_score); end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL wrong_key_ctl: got %0d pulses expected 0", pulses); end
    n_checks++;
    if (leds !== 4'b0001) begin n_errors++; $display("FAIL wrong_key_leds: got %b expected 0001", leds); end
    keys = '0;
  endtask

  task automatic test_saturate();
    fsm_state = 4'd0; tick(2);
    for (int k = 0; k < 255; k++) do_hit(k % 2);
    n_checks++;
    if (s_score !== 8'd255) begin n_errors++; $display("FAIL sat_reach: got %0d expected 255", s_score); end
    do_hit(1);
    n_checks++;
    if (s_score !== 8'd255) begin n_errors++; $display("FAIL sat_hold: got %0d expected 255", s_score); end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; fsm_state = 4'd0; keys = '0;
    test_reset();
    test_gap();
    test_hit();
    test_timeout();
    test_timer();
    test_penalty();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
